pcf8591_i2c_slave: RTL

Synthesizable I2C target that emulates a PCF8591 ADC/DAC on the bus. It answers the same transactions the on-board PCF8591 controller and generic I2C master issue: control byte plus DAC data on writes, and conversion results on reads. It sits on the board-side I2C pins as a bench and bring-up stand-in for the real chip, and exposes the emulated DAC and analog inputs as parallel ports.

---
 rtl/pcf8591_pkg.sv | 32 +++
 rtl/pcf8591_i2c_slave_sync.sv | 53 +++++
 rtl/pcf8591_i2c_slave.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pcf8591_pkg.sv
// Shared constants and types for the PCF8591 I2C target emulation.
// Control-byte bit positions mirror the real chip's control register layout.
package pcf8591_pkg;

   localparam logic [6:0] PCF_BASE_ADDR  = 7'h48;
   localparam logic [7:0] RESULT_RST_DEF = 8'h80;

   localparam int AOUT_EN  = 6;
   localparam int AUTO_INC = 2;
   localparam int CH_MSB   = 1;
   localparam int CH_LSB   = 0;

   localparam int             BIT_CNT_W = 4;
   localparam logic [3:0]     BYTE_BITS = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_IGNORE
   } state_e;

   // Pick one 8-bit channel sample out of the packed ain bus.
   function automatic logic [7:0] ch_select(input logic [31:0] samples, input logic [1:0] ch);
      return samples[{ch, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/pcf8591_i2c_slave_sync.sv
// Two-flop synchronizer for SCL/SDA plus registered SCL edge and START/STOP pulses.
// All pulses appear three sys_clk after the pin change and last one cycle.
module i2c_line_sync (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_prev_q;
   logic       sda_prev_q;
   logic       scl_rise_q;
   logic       scl_fall_q;
   logic       start_q;
   logic       stop_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         // Lines reset to the idle-bus level so reset release never looks like an edge.
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
         scl_rise_q <= scl_sync_q[1] & ~scl_prev_q;
         scl_fall_q <= ~scl_sync_q[1] & scl_prev_q;
         start_q    <= ~sda_sync_q[1] & sda_prev_q & scl_sync_q[1] & scl_prev_q;
         stop_q     <= sda_sync_q[1] & ~sda_prev_q & scl_sync_q[1] & scl_prev_q;
      end
   end

   assign sda_o      = sda_prev_q;
   assign scl_rise_o = scl_rise_q;
   assign scl_fall_o = scl_fall_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;

endmodule

// File: rtl/pcf8591_i2c_slave.sv
// I2C target emulating a PCF8591: control byte and DAC data on writes,
// channel conversion results on reads, exposed as parallel ports.
module pcf8591_i2c_slave
   import pcf8591_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = PCF_BASE_ADDR,
   parameter logic [7:0] RESULT_RST = RESULT_RST_DEF
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   input  logic [31:0] ain,
   output logic [7:0]  ctrl_byte,
   output logic [7:0]  dac_data,
   output logic        dac_en,
   output logic        wr_strobe,
   output logic        rd_strobe
);

   logic sda_lvl;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_line_sync u_sync (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_o      (sda_lvl),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   state_e                 state_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic [7:0]             shift_q;
   logic                   rw_q;
   logic                   first_q;
   logic                   mst_ack_q;
   logic [1:0]             ptr_q;
   logic [7:0]             result_q;
   logic [7:0]             ctrl_q;
   logic [7:0]             dac_q;
   logic                   sda_oe_q;
   logic                   wr_strobe_q;
   logic                   rd_strobe_q;

   logic [7:0]             ain_sel_d;
   logic [1:0]             ptr_d;
   logic                   addr_hit_d;
   logic                   tx_bit_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_d;

   always_comb begin
      ain_sel_d  = ch_select(ain, ptr_q);
      ptr_d      = ctrl_q[AUTO_INC] ? ptr_q + 2'd1 : ptr_q;
      addr_hit_d = (shift_q[7:1] == DEV_ADDR);
      // Bits 6..0 are driven after rises 1..7; bit 7 is driven on entry to RD_BYTE.
      tx_bit_d   = result_q[3'd7 - bit_cnt_q[2:0]];
      bit_cnt_d  = (bit_cnt_q == BYTE_BITS) ? bit_cnt_q : bit_cnt_q + 4'd1;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         first_q     <= 1'b0;
         mst_ack_q   <= 1'b0;
         ptr_q       <= 2'd0;
         result_q    <= RESULT_RST;
         ctrl_q      <= '0;
         dac_q       <= '0;
         sda_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         rd_strobe_q <= 1'b0;
      end else begin
         wr_strobe_q <= 1'b0;
         rd_strobe_q <= 1'b0;
         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
         end else if (stop_det) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], sda_lvl};
                     bit_cnt_q <= bit_cnt_d;
                  end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                     if (addr_hit_d) begin
                        state_q  <= ST_ADDR_ACK;
                        sda_oe_q <= 1'b1;
                        rw_q     <= shift_q[0];
                     end else begin
                        state_q  <= ST_IGNORE;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt_q <= '0;
                     if (rw_q) begin
                        state_q  <= ST_RD_BYTE;
                        sda_oe_q <= ~result_q[7];
                     end else begin
                        state_q  <= ST_WR_BYTE;
                        sda_oe_q <= 1'b0;
                        first_q  <= 1'b1;
                     end
                  end
               end
               ST_WR_BYTE: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], sda_lvl};
                     bit_cnt_q <= bit_cnt_d;
                  end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                     state_q  <= ST_WR_ACK;
                     sda_oe_q <= 1'b1;
                     if (first_q) begin
                        ctrl_q  <= shift_q;
                        ptr_q   <= shift_q[CH_MSB:CH_LSB];
                        first_q <= 1'b0;
                     end else begin
                        dac_q       <= shift_q;
                        wr_strobe_q <= 1'b1;
                     end
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     state_q   <= ST_WR_BYTE;
                     bit_cnt_q <= '0;
                     sda_oe_q  <= 1'b0;
                  end
               end
               ST_RD_BYTE: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_d;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == BYTE_BITS) begin
                        // Byte done: release for the master's ACK and take the next conversion.
                        state_q     <= ST_RD_ACK;
                        sda_oe_q    <= 1'b0;
                        result_q    <= ain_sel_d;
                        ptr_q       <= ptr_d;
                        rd_strobe_q <= 1'b1;
                     end else begin
                        sda_oe_q <= ~tx_bit_d;
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     mst_ack_q <= ~sda_lvl;
                  end else if (scl_fall) begin
                     bit_cnt_q <= '0;
                     if (mst_ack_q) begin
                        state_q  <= ST_RD_BYTE;
                        sda_oe_q <= ~result_q[7];
                     end else begin
                        state_q  <= ST_IGNORE;
                        sda_oe_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign ctrl_byte = ctrl_q;
   assign dac_data  = dac_q;
   assign dac_en    = ctrl_q[AOUT_EN];
   assign wr_strobe = wr_strobe_q;
   assign rd_strobe = rd_strobe_q;

endmodule
